// File: rtl/fp_sched_pkg.sv
// rtl/fp_sched_pkg.sv - shared types and constants for the FP divide/sqrt scheduler
package fp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } sched_state_t;

  localparam logic OP_FDIV  = 1'b0;
  localparam logic OP_FSQRT = 1'b1;

  localparam int DEF_DIV_CYCLES  = 24;
  localparam int DEF_SQRT_CYCLES = 24;

  // The counter only ever holds N-1, so clog2 of the larger count is enough.
  function automatic int cnt_width(input int div_cycles, input int sqrt_cycles);
    int m;
    m = (div_cycles > sqrt_cycles) ? div_cycles : sqrt_cycles;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fp_hazard_check.sv
// rtl/fp_hazard_check.sv - RAW/WAW/write-port hazard compare against the outstanding rd
module fp_hazard_check (
  input  logic       busy,
  input  logic       in_wb,
  input  logic [4:0] rd_q,
  input  logic [4:0] pipe_rs1,
  input  logic [4:0] pipe_rs2,
  input  logic [4:0] pipe_rd,
  input  logic       pipe_rs1_fp,
  input  logic       pipe_rs2_fp,
  input  logic       pipe_fp_we,
  output logic       hazard_stall
);

  logic raw_hit;
  logic waw_hit;
  logic port_hit;

  // f0 is an ordinary FP register, so no zero-register exclusion here.
  assign raw_hit  = busy && ((pipe_rs1_fp && (pipe_rs1 == rd_q)) ||
                             (pipe_rs2_fp && (pipe_rs2 == rd_q)));
  assign waw_hit  = busy && pipe_fp_we && (pipe_rd == rd_q);
  assign port_hit = in_wb && pipe_fp_we;

  assign hazard_stall = raw_hit || waw_hit || port_hit;

endmodule

// File: rtl/fp_iter_sched.sv
// rtl/fp_iter_sched.sv - issue/track/writeback scheduler for the iterative fdiv.s/fsqrt.s unit
module fp_iter_sched
  import fp_sched_pkg::*;
#(
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int SQRT_CYCLES = DEF_SQRT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_op,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  pipe_rs1,
  input  logic [4:0]  pipe_rs2,
  input  logic [4:0]  pipe_rd,
  input  logic        pipe_rs1_fp,
  input  logic        pipe_rs2_fp,
  input  logic        pipe_fp_we,
  input  logic [31:0] unit_result,
  output logic        unit_start,
  output logic        unit_op,
  output logic        stall,
  output logic        busy,
  output logic        wb_sel,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int CNT_W = cnt_width(DIV_CYCLES, SQRT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_CYCLES - 1);

  sched_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;
  logic             op_q;
  logic [31:0]      result_q;

  logic hazard_stall;
  logic accept;
  logic cnt_done;

  fp_hazard_check u_hazard (
    .busy        (busy),
    .in_wb       (state == WB),
    .rd_q        (rd_q),
    .pipe_rs1    (pipe_rs1),
    .pipe_rs2    (pipe_rs2),
    .pipe_rd     (pipe_rd),
    .pipe_rs1_fp (pipe_rs1_fp),
    .pipe_rs2_fp (pipe_rs2_fp),
    .pipe_fp_we  (pipe_fp_we),
    .hazard_stall(hazard_stall)
  );

  assign busy     = (state != IDLE);
  assign stall    = (issue_valid && busy) || hazard_stall;
  assign accept   = (state == IDLE) && issue_valid && !stall;
  assign cnt_done = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_q     <= 5'd0;
      op_q     <= OP_FDIV;
      result_q <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            rd_q <= issue_rd;
            op_q <= issue_op;
            cnt  <= (issue_op == OP_FSQRT) ? SQRT_LOAD : DIV_LOAD;
          end
        end
        RUN: begin
          if (cnt_done) begin
            result_q <= unit_result;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    unit_start = 1'b0;
    unit_op    = op_q;
    wb_sel     = 1'b0;
    wb_we      = 1'b0;
    wb_rd      = 5'd0;
    wb_data    = 32'd0;
    case (state)
      IDLE: begin
        // Forward the decoded op so the unit sees it alongside the start pulse.
        unit_op = issue_op;
        if (accept) begin
          unit_start = 1'b1;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        if (cnt_done) state_nxt = WB;
      end
      WB: begin
        wb_sel    = 1'b1;
        wb_we     = 1'b1;
        wb_rd     = rd_q;
        wb_data   = result_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_iter_sched.sv
// tb/tb_fp_iter_sched.sv - directed bench for fp_iter_sched (DIV_CYCLES=24, SQRT_CYCLES=8)
module tb_fp_iter_sched;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_op;
  logic [4:0]  issue_rd;
  logic [4:0]  pipe_rs1;
  logic [4:0]  pipe_rs2;
  logic [4:0]  pipe_rd;
  logic        pipe_rs1_fp;
  logic        pipe_rs2_fp;
  logic        pipe_fp_we;
  logic [31:0] unit_result;
  logic        unit_start;
  logic        unit_op;
  logic        stall;
  logic        busy;
  logic        wb_sel;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int vec_cnt;
  int miscompare_cnt;
  logic we_seen;

  fp_iter_sched #(
    .DIV_CYCLES (24),
    .SQRT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_op   (issue_op),
    .issue_rd   (issue_rd),
    .pipe_rs1   (pipe_rs1),
    .pipe_rs2   (pipe_rs2),
    .pipe_rd    (pipe_rd),
    .pipe_rs1_fp(pipe_rs1_fp),
    .pipe_rs2_fp(pipe_rs2_fp),
    .pipe_fp_we (pipe_fp_we),
    .unit_result(unit_result),
    .unit_start (unit_start),
    .unit_op    (unit_op),
    .stall      (stall),
    .busy       (busy),
    .wb_sel     (wb_sel),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_cnt        = 0;
    miscompare_cnt = 0;
    rst            = 1'b1;
    issue_valid    = 1'b0;
    issue_op       = 1'b0;
    issue_rd       = 5'd0;
    pipe_rs1       = 5'd0;
    pipe_rs2       = 5'd0;
    pipe_rd        = 5'd0;
    pipe_rs1_fp    = 1'b0;
    pipe_rs2_fp    = 1'b0;
    pipe_fp_we     = 1'b0;
    unit_result    = 32'd0;

    repeat (2) tick;
    #1;
    check_vec("rst_busy", busy, 0);
    check_vec("rst_stall", stall, 0);
    check_vec("rst_start", unit_start, 0);
    check_vec("rst_wb_sel", wb_sel, 0);
    check_vec("rst_wb_we", wb_we, 0);
    check_vec("rst_wb_rd", wb_rd, 0);
    check_vec("rst_wb_data", wb_data, 0);
    rst = 1'b0;
    tick;

    // fdiv.s f5, RAW reader on f5 / f6 during RUN and WB
    issue_valid = 1'b1; issue_op = 1'b0; issue_rd = 5'd5;
    #1;
    check_vec("t1_start", unit_start, 1);
    check_vec("t1_stall_idle", stall, 0);
    check_vec("t1_op_idle", unit_op, 0);
    tick;
    issue_valid = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      unit_result = 32'hA000_0000 + k;
      pipe_rs1_fp = (k == 5 || k == 6 || k >= 20);
      pipe_rs1    = (k == 6) ? 5'd6 : 5'd5;
      #1;
      check_vec("t1_run_stall", stall, (k == 5 || k >= 20));
      check_vec("t1_run_busy", busy, 1);
      check_vec("t1_run_we", wb_we, 0);
      check_vec("t1_run_start", unit_start, 0);
      tick;
    end
    unit_result = 32'hDEAD_BEEF;
    #1;
    check_vec("t1_wb_we", wb_we, 1);
    check_vec("t1_wb_sel", wb_sel, 1);
    check_vec("t1_wb_rd", wb_rd, 5);
    check_vec("t1_wb_data", wb_data, 32'hA000_0018);
    check_vec("t1_wb_stall", stall, 1);
    tick;
    #1;
    check_vec("t1_post_busy", busy, 0);
    check_vec("t1_post_we", wb_we, 0);
    check_vec("t1_post_stall", stall, 0);
    pipe_rs1_fp = 1'b0;
    tick;

    // fsqrt.s f7, WAW check in RUN, port conflict in WB
    issue_valid = 1'b1; issue_op = 1'b1; issue_rd = 5'd7;
    #1;
    check_vec("t2_start", unit_start, 1);
    check_vec("t2_op_idle", unit_op, 1);
    tick;
    issue_valid = 1'b0; issue_op = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      unit_result = 32'h5000_0000 + k;
      pipe_fp_we  = (k == 3 || k == 4);
      pipe_rd     = (k == 3) ? 5'd7 : 5'd9;
      #1;
      check_vec("t2_run_op", unit_op, 1);
      check_vec("t2_run_stall", stall, (k == 3));
      check_vec("t2_run_we", wb_we, 0);
      tick;
    end
    pipe_fp_we = 1'b1; pipe_rd = 5'd9;
    #1;
    check_vec("t2_wb_we", wb_we, 1);
    check_vec("t2_wb_sel", wb_sel, 1);
    check_vec("t2_wb_rd", wb_rd, 7);
    check_vec("t2_wb_data", wb_data, 32'h5000_0008);
    check_vec("t2_wb_stall", stall, 1);
    tick;
    #1;
    check_vec("t2_post_stall", stall, 0);
    check_vec("t2_post_sel", wb_sel, 0);
    check_vec("t2_post_busy", busy, 0);
    pipe_fp_we = 1'b0;
    tick;

    // back-to-back fdiv.s: f3 then f4 held from T+3 (dropped once at T+10)
    issue_valid = 1'b1; issue_op = 1'b0; issue_rd = 5'd3;
    #1;
    check_vec("t3_start_a", unit_start, 1);
    tick;
    for (int k = 1; k <= 25; k++) begin
      issue_valid = (k >= 3 && k != 10);
      issue_rd    = 5'd4;
      unit_result = 32'h3000_0000 + k;
      #1;
      if (k >= 3) begin
        check_vec("t3_hold_stall", stall, (k != 10));
        check_vec("t3_hold_start", unit_start, 0);
      end
      if (k == 25) begin
        check_vec("t3_wb_a_rd", wb_rd, 3);
        check_vec("t3_wb_a_data", wb_data, 32'h3000_0018);
      end
      tick;
    end
    issue_valid = 1'b1;
    #1;
    check_vec("t3_accept_stall", stall, 0);
    check_vec("t3_accept_start", unit_start, 1);
    check_vec("t3_accept_busy", busy, 0);
    tick;
    issue_valid = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      unit_result = 32'h4000_0000 + k;
      tick;
    end
    #1;
    check_vec("t3_wb_b_we", wb_we, 1);
    check_vec("t3_wb_b_rd", wb_rd, 4);
    check_vec("t3_wb_b_data", wb_data, 32'h4000_0018);
    tick;

    // reset pulsed at T+10 of fdiv.s f8
    issue_valid = 1'b1; issue_op = 1'b0; issue_rd = 5'd8;
    tick;
    issue_valid = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check_vec("t4_busy", busy, 0);
    check_vec("t4_stall", stall, 0);
    check_vec("t4_start", unit_start, 0);
    check_vec("t4_op", unit_op, 0);
    check_vec("t4_wb_sel", wb_sel, 0);
    check_vec("t4_wb_we", wb_we, 0);
    check_vec("t4_wb_rd", wb_rd, 0);
    check_vec("t4_wb_data", wb_data, 0);
    we_seen = 1'b0;
    repeat (30) begin
      #1;
      if (wb_we) we_seen = 1'b1;
      tick;
    end
    check_vec("t4_no_wb", we_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
